// File: rtl/pipes_pkg.sv
// Shared pipeline definitions: fetch FSM states, the hazard-unit PC-write encoding,
// common word types and the architectural reset/NOP constants.
package pipes;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    REQ   = 2'b01,
    READY = 2'b10,
    DRAIN = 2'b11
  } fetch_state_t;

  // pc_write from the hazard unit; any code with bit 1 set means "keep".
  typedef logic [1:0] pc_ctl_t;

  localparam pc_ctl_t PC_STREAM = 2'b00;
  localparam pc_ctl_t PC_FLUSH  = 2'b01;

  localparam u64 PCINIT    = 64'h0000_0000_8000_0000;
  localparam u32 NOP_INSTR = 32'h0000_0013;

  function automatic logic pc_ctl_is_keep(input pc_ctl_t ctl);
    return ctl[1];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding ibus handshake and
// presents one instruction to F/D. Define FETCH_MISALIGN_EXC_EN to trap misaligned fetches.
module fetch_unit
  import pipes::*;
#(
  parameter u64 PC_RESET = PCINIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_write,
  input  logic        pc_sel,
  input  logic [63:0] pc_target,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exc
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           req_addr_q, req_addr_d;
  u32           instr_buf_q, instr_buf_d;
  logic         exc_q, exc_d;
  logic         misaligned;
  pc_ctl_t      pc_ctl;

  assign pc_ctl = pc_write;

`ifdef FETCH_MISALIGN_EXC_EN
  assign misaligned = (req_addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every signal gets its hold value before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    instr_buf_d = instr_buf_q;
    exc_d       = exc_q;

    unique case (state_q)
      BOOT: begin
        state_d    = REQ;
        pc_d       = PC_RESET;
        req_addr_d = PC_RESET;
      end

      REQ: begin
        if (pc_sel && (iresp_data_ok || misaligned)) begin
          // Nothing left outstanding on the bus, so the redirect issues immediately.
          pc_d       = pc_target;
          req_addr_d = pc_target;
        end else if (pc_sel) begin
          pc_d    = pc_target;
          state_d = DRAIN;
        end else if (misaligned) begin
          instr_buf_d = NOP_INSTR;
          exc_d       = 1'b1;
          state_d     = READY;
        end else if (iresp_data_ok) begin
          instr_buf_d = iresp_data;
          exc_d       = 1'b0;
          state_d     = READY;
        end
      end

      DRAIN: begin
        if (pc_sel) begin
          pc_d = pc_target;
        end
        // The bus address is frozen until the stale response lands; then the newest target wins.
        if (iresp_data_ok) begin
          req_addr_d = pc_d;
          state_d    = REQ;
        end
      end

      READY: begin
        if (pc_sel) begin
          pc_d       = pc_target;
          req_addr_d = pc_target;
          state_d    = REQ;
        end else if (pc_ctl == PC_STREAM) begin
          pc_d       = req_addr_q + 64'd4;
          req_addr_d = req_addr_q + 64'd4;
          state_d    = REQ;
        end else if (pc_ctl == PC_FLUSH) begin
          pc_d    = req_addr_q;
          state_d = REQ;
        end else if (pc_ctl_is_keep(pc_ctl)) begin
          state_d = READY;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= PC_RESET;
      req_addr_q  <= PC_RESET;
      instr_buf_q <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      instr_buf_q <= instr_buf_d;
      exc_q       <= exc_d;
    end
  end

  // Outputs decode registered state only; BOOT (and reset) forces everything to zero.
  assign ireq_valid = ((state_q == REQ) && !misaligned) || (state_q == DRAIN);
  assign ireq_addr  = ireq_valid ? req_addr_q : '0;
  assign f_valid    = (state_q == READY);
  assign f_pc       = f_valid ? req_addr_q : '0;
  assign f_instr    = f_valid ? instr_buf_q : '0;
  assign f_exc      = f_valid & exc_q;

endmodule
